// File: rtl/lifo_seq_ctrl.sv
// rtl/lifo_seq_ctrl.sv - stream sequencer that reverses frames through an external stack
//
// Purpose: accepts an input stream and pushes words into a stack (LIFO) until a
// segment closes, either on s_last_i or when the stack is at capacity. It then
// pops the words out in reverse order into a registered output stream. Frames
// longer than LIFO_DEPTH are reversed in LIFO_DEPTH-word segments. m_last_o
// marks only the final word of a segment closed by s_last_i.
//
// Optional feature macro: LIFO_SEQ_CLR_ON_SEGMENT_EN. When it is defined, a
// one-cycle CLEAR state follows every drained segment and pulses lifo_clr_o.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   s_valid_i/s_ready_o/s_data_i/s_last_i   input stream
//   m_valid_o/m_ready_i/m_data_o/m_last_o   registered output stream
//   lifo_enb_o/clr_o/push_o/pop_o   stack controls (combinational)
//   lifo_datain_o                   stack write data (s_data_i)
//   lifo_dataout_i                  stack read data, valid in the pop cycle
//   lifo_full_i/lifo_empty_i        stack status
//   err_o                           sticky protocol error
module lifo_seq_ctrl #(
  parameter int DATA_BITS  = 32,
  parameter int LIFO_DEPTH = 4,
  parameter int CNT_BITS   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DATA_BITS-1:0] s_data_i,
  input  logic                 s_last_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_last_o,
  output logic                 lifo_enb_o,
  output logic                 lifo_clr_o,
  output logic                 lifo_push_o,
  output logic                 lifo_pop_o,
  output logic [DATA_BITS-1:0] lifo_datain_o,
  input  logic [DATA_BITS-1:0] lifo_dataout_i,
  input  logic                 lifo_full_i,
  input  logic                 lifo_empty_i,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1
`ifdef LIFO_SEQ_CLR_ON_SEGMENT_EN
    ,CLEAR = 2'd2
`endif
  } state_t;

  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(LIFO_DEPTH);
  localparam logic [CNT_BITS-1:0] ONE_C   = CNT_BITS'(1);

  state_t                state, state_nxt;
  logic [CNT_BITS-1:0]   cnt, cnt_nxt;
  logic                  seg_last, seg_last_nxt;
  logic                  err_set;
  logic                  cnt_lt_depth;
  logic                  out_free;
  logic                  fill_ready;

  assign cnt_lt_depth  = (cnt < DEPTH_C);
  // Output register can take a new word if empty or being accepted now.
  assign out_free      = ~m_valid_o | m_ready_i;
  assign lifo_datain_o = s_data_i;
  assign lifo_enb_o    = lifo_push_o | lifo_pop_o;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    seg_last_nxt = seg_last;
    fill_ready   = 1'b0;
    s_ready_o    = 1'b0;
    lifo_push_o  = 1'b0;
    lifo_pop_o   = 1'b0;
    lifo_clr_o   = 1'b0;
    err_set      = 1'b0;

    case (state)
      FILL: begin
        fill_ready = cnt_lt_depth & ~lifo_full_i;
        s_ready_o  = fill_ready;
        if (cnt_lt_depth & lifo_full_i) begin
          // Stack claims full before we filled it: resynchronise by clearing.
          err_set    = 1'b1;
          lifo_clr_o = 1'b1;
          cnt_nxt    = '0;
        end else if (s_valid_i & fill_ready) begin
          lifo_push_o = 1'b1;
          cnt_nxt     = cnt + ONE_C;
          if (s_last_i | ((cnt + ONE_C) == DEPTH_C)) begin
            state_nxt    = DRAIN;
            seg_last_nxt = s_last_i;
          end
        end
      end

      DRAIN: begin
        if ((cnt != '0) & out_free) begin
          if (lifo_empty_i) begin
            // Stack ran dry before our count did: drop the segment.
            err_set    = 1'b1;
            lifo_clr_o = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = FILL;
          end else begin
            lifo_pop_o = 1'b1;
            cnt_nxt    = cnt - ONE_C;
          end
        end else if ((cnt == '0) & out_free) begin
`ifdef LIFO_SEQ_CLR_ON_SEGMENT_EN
          state_nxt = CLEAR;
`else
          state_nxt = FILL;
`endif
        end
      end

`ifdef LIFO_SEQ_CLR_ON_SEGMENT_EN
      CLEAR: begin
        lifo_clr_o = 1'b1;
        state_nxt  = FILL;
      end
`endif

      default: begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      seg_last  <= 1'b0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      seg_last <= seg_last_nxt;
      if (err_set) begin
        err_o <= 1'b1;
      end
      if (lifo_pop_o) begin
        m_valid_o <= 1'b1;
        m_data_o  <= lifo_dataout_i;
        // The pop with cnt == 1 takes the bottom word, i.e. the segment's first input.
        m_last_o  <= seg_last & (cnt == ONE_C);
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lifo_seq_ctrl.sv
// tb/tb_lifo_seq_ctrl.sv - self-checking bench for lifo_seq_ctrl
module tb_lifo_seq_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CB    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid_i, s_ready_o, s_last_i;
  logic [DW-1:0] s_data_i;
  logic          m_valid_o, m_ready_i, m_last_o;
  logic [DW-1:0] m_data_o;
  logic          lifo_enb_o, lifo_clr_o, lifo_push_o, lifo_pop_o;
  logic [DW-1:0] lifo_datain_o, lifo_dataout_i;
  logic          lifo_full_i, lifo_empty_i;
  logic          err_o;

  always #5 clk = ~clk;

  lifo_seq_ctrl #(.DATA_BITS(DW), .LIFO_DEPTH(DEPTH), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .lifo_enb_o(lifo_enb_o), .lifo_clr_o(lifo_clr_o), .lifo_push_o(lifo_push_o),
    .lifo_pop_o(lifo_pop_o), .lifo_datain_o(lifo_datain_o), .lifo_dataout_i(lifo_dataout_i),
    .lifo_full_i(lifo_full_i), .lifo_empty_i(lifo_empty_i), .err_o(err_o)
  );

  // Behavioural stack the sequencer drives.
  logic [DW-1:0] stk [0:(2**CB)-1];
  logic [CB-1:0] sp;
  logic          force_empty;

  always @(posedge clk) begin
    if (rst || lifo_clr_o) sp <= '0;
    else if (lifo_enb_o && lifo_push_o && sp < CB'(DEPTH)) begin
      stk[sp] <= lifo_datain_o;
      sp      <= sp + 1'b1;
    end else if (lifo_enb_o && lifo_pop_o && sp != '0) sp <= sp - 1'b1;
  end

  always_comb begin
    lifo_dataout_i = '0;
    if (sp != '0) lifo_dataout_i = stk[sp - 1'b1];
  end
  assign lifo_full_i  = (sp == CB'(DEPTH));
  assign lifo_empty_i = (sp == '0) || force_empty;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          eos;
  } beat_t;

  beat_t         in_q[$];
  beat_t         exp_q[$];
  logic [DW-1:0] frame_buf[$];
  logic [3:0]    rdy_pat;
  bit            rnd_mode;
  int            rdy_pct, vld_pct;

  // Reference: split the frame into DEPTH-word chunks, reverse each chunk;
  // only the final word out of the final chunk carries last.
  task automatic add_frame();
    int n = frame_buf.size();
    for (int k = 0; k < n; k++) in_q.push_back('{frame_buf[k], (k == n - 1), 1'b0});
    for (int s = 0; s < n; s += DEPTH) begin
      int e = (s + DEPTH < n) ? s + DEPTH : n;
      for (int k = e - 1; k >= s; k--)
        exp_q.push_back('{frame_buf[k], (e == n) && (k == s), (k == s)});
    end
  endtask

  task automatic run(input int max_cyc, input bit chk_lat, input int exp_pops, input int exp_clrs);
    int            n = 0;
    int            ta = -1;
    int            acc_cyc = -1;
    int            pops = 0;
    int            clrs = 0;
    bit            first_seen = 0;
    bit            hold = 0;
    logic [DW-1:0] hold_d = '0;
    while (n < max_cyc) begin
      @(negedge clk);
      if (in_q.size() > 0 && (!rnd_mode || $urandom_range(99) < vld_pct)) begin
        s_valid_i = 1'b1; s_data_i = in_q[0].d; s_last_i = in_q[0].l;
      end else begin
        s_valid_i = 1'b0; s_data_i = $urandom; s_last_i = 1'($urandom);
      end
      m_ready_i = rnd_mode ? ($urandom_range(99) < rdy_pct) : rdy_pat[n % 4];
      #1;
`ifdef LIFO_SEQ_CLR_ON_SEGMENT_EN
      if (ta == 1) begin
        chk("clear_pulse", lifo_clr_o, 1'b1);
        chk("ready_low_in_clear", s_ready_o, 1'b0);
      end
      if (ta == 2) chk("ready_after_clear", s_ready_o, 1'b1);
`else
      if (ta == 1) begin
        chk("ready_after_drain", s_ready_o, 1'b1);
        chk("no_clr_pulse", lifo_clr_o, 1'b0);
      end
`endif
      chk("push_pop_excl", lifo_push_o & lifo_pop_o, 1'b0);
      chk("enb_vs_cmd", lifo_enb_o, lifo_push_o | lifo_pop_o);
      if (m_valid_o) chk("ready_low_in_drain", s_ready_o, 1'b0);
      if (hold) begin
        chk("hold_valid", m_valid_o, 1'b1);
        chk("hold_data", m_data_o, hold_d);
      end
      if (chk_lat && m_valid_o && !first_seen) begin
        first_seen = 1;
        chk("first_valid_latency", n - acc_cyc, 2);
      end
      if (lifo_pop_o) pops++;
      if (lifo_clr_o) clrs++;
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("extra_output", 1'b1, 1'b0);
        else begin
          chk("out_data", m_data_o, exp_q[0].d);
          chk("out_last", m_last_o, exp_q[0].l);
          if (exp_q[0].eos) ta = 0;
          void'(exp_q.pop_front());
        end
      end
      if (s_valid_i && s_ready_o) begin
        if (in_q[0].l) acc_cyc = n;
        void'(in_q.pop_front());
      end
      hold   = m_valid_o && !m_ready_i;
      hold_d = m_data_o;
      if (ta >= 0) ta++;
      if (ta > 2) ta = -1;
      n++;
      if (in_q.size() == 0 && exp_q.size() == 0 && !m_valid_o && ta < 0) break;
    end
    chk("run_complete", (in_q.size() == 0) && (exp_q.size() == 0), 1'b1);
    chk("pop_count", pops, exp_pops);
    chk("clr_count", clrs, exp_clrs);
    chk("stack_drained", sp, 0);
    s_valid_i = 1'b0;
    in_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int                 len;
    logic [DW-1:0]      base;
    logic [7:0][DW-1:0] e;
    logic [7:0]         lm;
    logic [3:0]         rp;
    bit                 lat;
  } vec_t;

  vec_t vt[7];

  function automatic int segs(input int len);
    return (len + DEPTH - 1) / DEPTH;
  endfunction

  function automatic int exp_clr(input int len);
`ifdef LIFO_SEQ_CLR_ON_SEGMENT_EN
    return segs(len);
`else
    return (len < 0) ? 1 : 0;
`endif
  endfunction

  task automatic apply_vec(input int i);
    for (int k = 0; k < vt[i].len; k++)
      in_q.push_back('{vt[i].base + DW'(k), (k == vt[i].len - 1), 1'b0});
    for (int j = 0; j < vt[i].len; j++)
      exp_q.push_back('{vt[i].e[j], vt[i].lm[j], (j % DEPTH == DEPTH - 1) || (j == vt[i].len - 1)});
    rnd_mode = 0;
    rdy_pat  = vt[i].rp;
    run(200, vt[i].lat, vt[i].len, exp_clr(vt[i].len));
  endtask

  initial begin
    // Directed vectors: input words are base, base+1, ...
    vt[0] = '{len:3, base:'hA0, e:'0, lm:8'h04, rp:4'b1111, lat:1'b1};
    vt[0].e[0] = 'hA2; vt[0].e[1] = 'hA1; vt[0].e[2] = 'hA0;
    vt[1] = '{len:6, base:1, e:'0, lm:8'h20, rp:4'b1111, lat:1'b0};
    vt[1].e[0] = 4; vt[1].e[1] = 3; vt[1].e[2] = 2; vt[1].e[3] = 1; vt[1].e[4] = 6; vt[1].e[5] = 5;
    vt[2] = '{len:3, base:'h31, e:'0, lm:8'h04, rp:4'b1001, lat:1'b0};
    vt[2].e[0] = 'h33; vt[2].e[1] = 'h32; vt[2].e[2] = 'h31;
    vt[3] = '{len:4, base:1, e:'0, lm:8'h08, rp:4'b1011, lat:1'b0};
    vt[3].e[0] = 4; vt[3].e[1] = 3; vt[3].e[2] = 2; vt[3].e[3] = 1;
    vt[4] = '{len:1, base:'h55, e:'0, lm:8'h01, rp:4'b1111, lat:1'b0};
    vt[4].e[0] = 'h55;
    vt[5] = '{len:5, base:'h10, e:'0, lm:8'h10, rp:4'b1110, lat:1'b0};
    vt[5].e[0] = 'h13; vt[5].e[1] = 'h12; vt[5].e[2] = 'h11; vt[5].e[3] = 'h10; vt[5].e[4] = 'h14;
    vt[6] = '{len:2, base:'hB0, e:'0, lm:8'h02, rp:4'b1111, lat:1'b0};
    vt[6].e[0] = 'hB1; vt[6].e[1] = 'hB0;

    rst = 1'b1; s_valid_i = 0; s_data_i = '0; s_last_i = 0; m_ready_i = 0;
    force_empty = 0; rnd_mode = 0; rdy_pat = 4'hF; rdy_pct = 70; vld_pct = 80;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_s_ready", s_ready_o, 1'b1);
    chk("rst_m_valid", m_valid_o, 1'b0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_m_last", m_last_o, 1'b0);
    chk("rst_lifo_ctl", {lifo_enb_o, lifo_clr_o, lifo_push_o, lifo_pop_o}, 4'b0000);
    chk("rst_err", err_o, 1'b0);

    for (int i = 0; i < 7; i++) apply_vec(i);

    // Stack reports empty while two words are still counted.
    @(negedge clk); s_valid_i = 1; s_data_i = 'hE0; s_last_i = 0; m_ready_i = 1; #1;
    chk("err_seq_ready", s_ready_o, 1'b1);
    @(negedge clk); s_data_i = 'hE1; s_last_i = 1;
    @(negedge clk); s_valid_i = 0; s_last_i = 0; force_empty = 1; #1;
    chk("err_no_pop", lifo_pop_o, 1'b0);
    chk("err_clr_pulse", lifo_clr_o, 1'b1);
    chk("err_no_enb", lifo_enb_o, 1'b0);
    @(negedge clk); force_empty = 0; #1;
    chk("err_set", err_o, 1'b1);
    chk("err_back_to_fill", s_ready_o, 1'b1);
    chk("err_no_output", m_valid_o, 1'b0);
    chk("err_clr_once", lifo_clr_o, 1'b0);
    apply_vec(4);
    chk("err_sticky", err_o, 1'b1);

    // Reset in the middle of a drain, after one word has left.
    begin
      bit found = 0;
      m_ready_i = 1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); s_valid_i = 1; s_data_i = 'hC0 + DW'(k); s_last_i = (k == 2);
      end
      @(negedge clk); s_valid_i = 0; s_last_i = 0;
      for (int k = 0; k < 10 && !found; k++) begin
        #1;
        if (m_valid_o && m_ready_i) found = 1;
        else @(negedge clk);
      end
      chk("rst_seq_first_out", found, 1'b1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      chk("mid_rst_s_ready", s_ready_o, 1'b1);
      chk("mid_rst_m_valid", m_valid_o, 1'b0);
      chk("mid_rst_m_data", m_data_o, 0);
      chk("mid_rst_m_last", m_last_o, 1'b0);
      chk("mid_rst_lifo_ctl", {lifo_enb_o, lifo_clr_o, lifo_push_o, lifo_pop_o}, 4'b0000);
      chk("mid_rst_err", err_o, 1'b0);
      apply_vec(0);
      apply_vec(1);
    end

    // Random frames against the chunk-reversal reference.
    rnd_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 10);
      rdy_pct = $urandom_range(30, 100);
      vld_pct = $urandom_range(40, 100);
      frame_buf.delete();
      for (int k = 0; k < len; k++) frame_buf.push_back($urandom);
      add_frame();
      run(2000, 1'b0, len, exp_clr(len));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
